// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RV32I funct3 codes and lane mask width.
// No logic of its own; the helpers are pure combinational decodes of a request.
// Backpressure is not applicable here.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LANE_W = 4;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3[2] | (f3[1:0] == 2'b11);
        return (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// slave = the lsu itself; master = the core plus data memory driving it.
// Requests wait on req_ready; responses and memory strobes have no backpressure.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        dmem_load;
    logic        dmem_store;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               dmem_load, dmem_store, dmem_addr, dmem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               dmem_load, dmem_store, dmem_addr, dmem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Sub-word lane logic: load extract/extend and byte/halfword store merge into a read word.
// Purely combinational, zero latency.
// No backpressure; the caller samples the outputs when it needs them.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [1:0]        off;
    logic [LANE_W-1:0] mask;
    logic [31:0]       repl;
    logic [31:0]       shifted;

    always_comb begin
        off        = 2'b00;
        mask       = '1;
        repl       = wdata;
        shifted    = rdata;
        load_data  = '0;
        merge_data = rdata;

        // Misaligned halfwords/words are force-aligned by ignoring the low offset bits.
        case (funct3[1:0])
            2'b00: begin
                off  = addr_lo;
                mask = LANE_W'(1) << addr_lo;
                repl = {4{wdata[7:0]}};
            end
            2'b01: begin
                off  = {addr_lo[1], 1'b0};
                mask = LANE_W'(3) << {addr_lo[1], 1'b0};
                repl = {2{wdata[15:0]}};
            end
            default: begin
                off  = 2'b00;
                mask = '1;
                repl = wdata;
            end
        endcase

        shifted = rdata >> {off, 3'b000};

        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase

        for (int i = 0; i < LANE_W; i++) begin
            if (mask[i])
                merge_data[8*i +: 8] = repl[8*i +: 8];
        end
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one request at a time, read-modify-write for SB/SH on a word-only memory.
// Latency: fault 1, SW 2, loads 3, SB/SH 4 cycles; LSU_MISALIGN_TRAP_EN turns misaligned accesses into faults.
// req_ready is high only in IDLE; responses and memory strobes are single-cycle pulses with no backpressure.
module lsu
    import lsu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        dmem_load_q;
    logic        dmem_store_q;
    logic        addr_act_q;
    logic [31:0] dmem_wdata_q;
    logic        resp_valid_q;
    logic        resp_fault_q;
    logic [31:0] resp_rdata_q;

    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        mis;
    logic        fault_in;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = f3_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign fault_in = f3_illegal(bus.req_we, bus.req_funct3) | mis;

    lsu_align u_align (
        .funct3     (f3_q),
        .addr_lo    (addr_q[1:0]),
        .rdata      (bus.dmem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            dmem_load_q  <= 1'b0;
            dmem_store_q <= 1'b0;
            addr_act_q   <= 1'b0;
            dmem_wdata_q <= '0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            dmem_load_q  <= 1'b0;
            dmem_store_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        if (fault_in) begin
                            state        <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                        end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
                            state        <= S_WRITE;
                            dmem_store_q <= 1'b1;
                            addr_act_q   <= 1'b1;
                            dmem_wdata_q <= bus.req_wdata;
                        end else begin
                            state       <= S_READ;
                            dmem_load_q <= 1'b1;
                            addr_act_q  <= 1'b1;
                        end
                    end
                end
                S_READ: state <= S_WAIT;
                S_WAIT: begin
                    if (we_q) begin
                        state        <= S_WRITE;
                        dmem_store_q <= 1'b1;
                        dmem_wdata_q <= merge_data;
                    end else begin
                        state        <= S_RESP;
                        addr_act_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data;
                    end
                end
                S_WRITE: begin
                    state        <= S_RESP;
                    addr_act_q   <= 1'b0;
                    dmem_wdata_q <= '0;
                    resp_valid_q <= 1'b1;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.dmem_load  = dmem_load_q;
    assign bus.dmem_store = dmem_store_q;
    assign bus.dmem_addr  = addr_act_q ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule
